// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//
// SPI slave front end for a small memory. Every SPI action happens on the
// rising edge of the system clock. A frame is 10 command bits on MOSI, MSB
// first. Bit 9 selects a write (0) or a read (1). Bit 8 and the payload
// complete the word. Read frames come in pairs: first an address frame, then
// a data frame. On the data frame the memory side answers with a byte, and
// that byte is shifted out on MISO, MSB first.
//
// Ports
//   clk       system clock; SPI sampling and driving happen on its rising edge
//   rst_n     synchronous active-low reset
//   SS_n      slave select, active-low; a high level ends or aborts a frame
//   MOSI      serial command/data in, MSB first
//   MISO      serial read data out, MSB first, registered
//   rx_data   assembled 10-bit command word ([9:8] opcode, [7:0] payload)
//   rx_valid  one-cycle pulse marking rx_data as complete
//   tx_data   read byte from the memory side
//   tx_valid  qualifies tx_data; looked at only while a read byte is awaited
// -----------------------------------------------------------------------------
module spi_slave_if (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Bit-counter values. The counter counts the 9 samples that follow the
  // opcode MSB. It parks at RX_DONE_CNT and does not wrap within a frame.
  localparam logic [3:0] RX_LAST_CNT = 4'd8;
  localparam logic [3:0] RX_DONE_CNT = 4'd9;
  // Bits still to shift out after the MSB. The MSB goes to MISO at the latch.
  localparam logic [2:0] TX_REST_CNT = 3'd7;

  state_t     r_state;
  state_t     w_next_state;

  logic [8:0] r_rx_shift;      // bits 9..1 of the word being assembled
  logic [3:0] r_bit_cnt;
  logic [9:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rd_addr_seen;  // an address frame arrived and its data frame has not
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_cnt;
  logic       r_tx_loaded;
  logic       r_miso;

  logic       w_data_state;
  logic       w_rx_active;
  logic       w_rx_last;

  assign w_data_state = (r_state == WRITE) || (r_state == READ_ADD) ||
                        (r_state == READ_DATA);
  assign w_rx_active  = w_data_state && (r_bit_cnt != RX_DONE_CNT);
  assign w_rx_last    = w_rx_active && (r_bit_cnt == RX_LAST_CNT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments, so every register
  // updates from the values that held before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top covers every path through the
  // case, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (!SS_n) w_next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)                w_next_state = IDLE;
        else if (!MOSI)          w_next_state = WRITE;
        else if (r_rd_addr_seen) w_next_state = READ_DATA;
        else                     w_next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive / transmit datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_shift     <= '0;
      r_bit_cnt      <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_tx_loaded    <= 1'b0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      if (SS_n || (r_state == IDLE)) begin
        // An idle or aborted frame drops its partial word and any pending
        // transmit. The IDLE edge that sees SS_n low is the CHK_CMD entry,
        // so this is also where the bit counter restarts. rd_addr_seen is
        // not touched.
        r_bit_cnt   <= '0;
        r_tx_cnt    <= '0;
        r_tx_loaded <= 1'b0;
        r_miso      <= 1'b0;
      end else if (r_state == CHK_CMD) begin
        r_rx_shift <= {8'd0, MOSI};
      end else if (w_rx_active) begin
        r_rx_shift <= {r_rx_shift[7:0], MOSI};
        r_bit_cnt  <= r_bit_cnt + 4'd1;
        if (w_rx_last) begin
          r_rx_data  <= {r_rx_shift, MOSI};
          r_rx_valid <= 1'b1;
          if (r_state == READ_ADD) begin
            r_rd_addr_seen <= 1'b1;
          end else if (r_state == READ_DATA) begin
            r_rd_addr_seen <= 1'b0;
          end
        end
      end else if (r_state == READ_DATA) begin
        if (!r_tx_loaded) begin
          // Wait, with no timeout, for the memory side. The MSB goes to MISO
          // right away. The shift register keeps the remaining bits
          // left-aligned.
          if (tx_valid) begin
            r_tx_loaded <= 1'b1;
            r_tx_shift  <= {tx_data[6:0], 1'b0};
            r_tx_cnt    <= TX_REST_CNT;
            r_miso      <= tx_data[7];
          end
        end else if (r_tx_cnt != 3'd0) begin
          r_miso     <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          r_tx_cnt   <= r_tx_cnt - 3'd1;
        end else begin
          r_miso <= 1'b0;
        end
      end
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule
